prog_clock_divider: RTL and testbench
=====================================

Name: prog_clock_divider

Overview:
Multi-channel, runtime-programmable clock divider for the 10 MHz system clock. Each channel makes either a 50%-duty divided clock (toggle mode) or a one-cycle strobe (pulse mode), with a reload handshake. New divisors take effect only at a period boundary, so the output never glitches. It feeds display multiplexing, debouncers and timers that each need their own rate.

Parameters:
CNT_WIDTH, 14, width of each channel's counter and half-period register
NUM_CH, 2, number of independent channels (>=1)
DEFAULT_HALF, 4999, reset value of every channel's half-period register (1 kHz from 10 MHz in toggle mode)

Ports:
inClock  input  1  system clock, all logic on its rising edge
resetN  input  1  asynchronous active-low reset
enable  input  1  global count enable; low = all channels freeze
syncClear  input  1  synchronous restart of all channels (phase alignment)
loadValid  input  1  request to reprogram channel loadCh
loadReady  output  1  load accepted this cycle when loadValid && loadReady
loadCh  input  max(1,clog2(NUM_CH))  target channel index
loadHalf  input  CNT_WIDTH  new terminal count N (period = N+1 cycles per phase)
loadMode  input  1  0 = toggle mode, 1 = pulse mode
outClock  output  NUM_CH  divided clocks (registered)
outTick  output  NUM_CH  one-cycle strobes (registered)

Behaviour:
- Reset (resetN low, async): counters 0, outClock 0, outTick 0, half = DEFAULT_HALF, mode = toggle, pending flags 0. loadReady is 1 once out of reset.
- Per channel: counter cnt, active half H, active mode M, pending register (Hp, Mp, pend flag).
- Terminal event: enable && cnt == H. On it cnt <= 0, else cnt <= cnt + 1 while enable.
- Toggle mode: outClock[i] inverts on every terminal event; outTick[i] is 1 for the cycle after a terminal event that drives outClock 0->1. Full period = 2(H+1) cycles. H=0 gives divide-by-2.
- Pulse mode: outClock[i] held 0; outTick[i] is 1 for one cycle after each terminal event; period H+1. H=0 gives outTick constantly 1 while enabled.
- Latency: from reset release with enable=1, the first outClock rise is registered on rising edge H+1 (counts 0..H inclusive).
- enable low: cnt, outClock and pending hold; outTick forced 0. No terminal events occur.
- Load handshake: loadReady = !pend[loadCh]. On accept, Hp/Mp <= loadHalf/loadMode and pend <= 1. loadValid with an out-of-range loadCh (>= NUM_CH) is accepted and dropped.
- Pending applied at that channel's next terminal event: H <= Hp, M <= Mp, pend <= 0. The new period starts from cnt = 0.
- Mode switch toggle->pulse: outClock forced 0 at the applying terminal event (no toggle). Pulse->toggle: outClock starts at 0; the first toggle is the next terminal event.
- Load and terminal event on the same cycle for the same channel: the load is captured to pending and applies at the following terminal event, not the current one.
- syncClear (priority over counting, works regardless of enable): all cnt <= 0, outClock <= 0, outTick <= 0. Any pending values are applied immediately. A load accepted on the same cycle as syncClear is also applied immediately.
- cnt > H is impossible by construction. The counter wraps only via terminal events, never via CNT_WIDTH overflow.
- Mid-operation reset: immediate return to reset values; in-flight pending is discarded.

Decomposition:
- Package prog_clock_divider_pkg: MODE_TOGGLE=1'b0, MODE_PULSE=1'b1, CH_IDX_W helper function (max(1,clog2)).
- Sub-module divider_channel: one counter, H/M/pending registers and output logic. It has ports inClock, resetN, enable, syncClear, ldStrobe, ldHalf, ldMode, pendOut, clkOut, tickOut. The top generates NUM_CH instances, decodes loadCh and muxes pend for loadReady.

Test Plan:
- Reset with DEFAULT_HALF overridden to 2, enable=1: outClock[0] rises at edge 3 and falls at edge 6, period 6; outTick[0] high only on cycles 3, 9, 15.
- Load ch1 H=0 in pulse mode while ch1 is mid-count at H=4: the change waits for ch1's terminal event. Then outClock[1]=0 and outTick[1] stays 1 every cycle. Ch0 is unaffected.
- Two back-to-back loads to ch0: loadReady drops after the first and rises the cycle after ch0's terminal event. Once it rises, the second load is accepted.
- enable=0 for 7 cycles mid-period: outClock holds, outTick=0, the counter holds. Resuming completes the period with exactly the remaining counts.
- syncClear with ch0 pending H=1: all outputs 0 the next cycle, and ch0 immediately runs period 4 in toggle mode.
- Async reset asserted mid-period with a pending load: outputs 0 at once. After release, the pending value has been discarded and the channel runs at DEFAULT_HALF.

Source files
------------

// File: rtl/prog_clock_divider_pkg.sv
// Shared constants and helpers for the
// programmable clock divider.
package prog_clock_divider_pkg;

  localparam logic MODE_TOGGLE = 1'b0;
  localparam logic MODE_PULSE  = 1'b1;

  // Channel index width, never narrower than one bit.
  function automatic int ch_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/prog_clock_divider_channel.sv
// One divider channel: counter, active and pending
// configuration, registered clock and strobe outputs.
module prog_clock_divider_channel
  import prog_clock_divider_pkg::*;
#(
  parameter int CNT_WIDTH    = 14,
  parameter int DEFAULT_HALF = 4999
) (
  input  logic                 inClock,
  input  logic                 resetN,
  input  logic                 enable,
  input  logic                 syncClear,
  input  logic                 ldStrobe,
  input  logic [CNT_WIDTH-1:0] ldHalf,
  input  logic                 ldMode,
  output logic                 pendOut,
  output logic                 clkOut,
  output logic                 tickOut
);

  localparam logic [CNT_WIDTH-1:0] RST_HALF =
    CNT_WIDTH'(DEFAULT_HALF);

  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [CNT_WIDTH-1:0] h_q, h_d;
  logic [CNT_WIDTH-1:0] hp_q, hp_d;
  logic                 m_q, m_d;
  logic                 mp_q, mp_d;
  logic                 pend_q, pend_d;
  logic                 clk_q, clk_d;
  logic                 tick_q, tick_d;
  logic                 term;

  // Next-state: clear has priority, pending config
  // is swapped in only at a period boundary.
  always_comb begin
    cnt_d  = cnt_q;
    h_d    = h_q;
    m_d    = m_q;
    hp_d   = hp_q;
    mp_d   = mp_q;
    pend_d = pend_q;
    clk_d  = clk_q;
    tick_d = 1'b0;
    term   = enable && (cnt_q == h_q);
    if (syncClear) begin
      cnt_d = '0;
      clk_d = 1'b0;
      if (ldStrobe) begin
        h_d    = ldHalf;
        m_d    = ldMode;
        pend_d = 1'b0;
      end else if (pend_q) begin
        h_d    = hp_q;
        m_d    = mp_q;
        pend_d = 1'b0;
      end
    end else begin
      if (term) begin
        cnt_d = '0;
        if (pend_q) begin
          h_d    = hp_q;
          m_d    = mp_q;
          pend_d = 1'b0;
        end
        // The mode in force after this event decides
        // the output; leaving pulse mode restarts low.
        if (m_d == MODE_PULSE) begin
          clk_d  = 1'b0;
          tick_d = 1'b1;
        end else if (m_q == MODE_PULSE) begin
          clk_d  = 1'b0;
        end else begin
          clk_d  = ~clk_q;
          tick_d = ~clk_q;
        end
      end else if (enable) begin
        cnt_d = cnt_q + 1'b1;
      end
      // A load landing on a terminal event waits for
      // the following one.
      if (ldStrobe) begin
        hp_d   = ldHalf;
        mp_d   = ldMode;
        pend_d = 1'b1;
      end
    end
  end

  // State registers with async active-low reset.
  always_ff @(posedge inClock or negedge resetN) begin
    if (!resetN) begin
      cnt_q  <= '0;
      h_q    <= RST_HALF;
      m_q    <= MODE_TOGGLE;
      hp_q   <= '0;
      mp_q   <= MODE_TOGGLE;
      pend_q <= 1'b0;
      clk_q  <= 1'b0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      h_q    <= h_d;
      m_q    <= m_d;
      hp_q   <= hp_d;
      mp_q   <= mp_d;
      pend_q <= pend_d;
      clk_q  <= clk_d;
      tick_q <= tick_d;
    end
  end

  assign pendOut = pend_q;
  assign clkOut  = clk_q;
  assign tickOut = tick_q;

endmodule

// File: rtl/prog_clock_divider.sv
// Multi-channel programmable clock divider with a
// reload handshake shared across channels.
module prog_clock_divider
  import prog_clock_divider_pkg::*;
#(
  parameter int CNT_WIDTH    = 14,
  parameter int NUM_CH       = 2,
  parameter int DEFAULT_HALF = 4999
) (
  input  logic                          inClock,
  input  logic                          resetN,
  input  logic                          enable,
  input  logic                          syncClear,
  input  logic                          loadValid,
  output logic                          loadReady,
  input  logic [ch_idx_w(NUM_CH)-1:0]   loadCh,
  input  logic [CNT_WIDTH-1:0]          loadHalf,
  input  logic                          loadMode,
  output logic [NUM_CH-1:0]             outClock,
  output logic [NUM_CH-1:0]             outTick
);

  localparam int IDX_W = ch_idx_w(NUM_CH);

  logic [NUM_CH-1:0] pend;
  logic [NUM_CH-1:0] ld_stb;
  logic              accept;

  // Ready reflects the target's pending slot; an
  // index past the last channel is always taken.
  always_comb begin
    loadReady = 1'b1;
    for (int i = 0; i < NUM_CH; i++) begin
      if (loadCh == IDX_W'(i)) begin
        loadReady = !pend[i];
      end
    end
  end

  assign accept = loadValid && loadReady;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    assign ld_stb[i] = accept && (loadCh == IDX_W'(i));

    prog_clock_divider_channel #(
      .CNT_WIDTH    (CNT_WIDTH),
      .DEFAULT_HALF (DEFAULT_HALF)
    ) u_ch (
      .inClock   (inClock),
      .resetN    (resetN),
      .enable    (enable),
      .syncClear (syncClear),
      .ldStrobe  (ld_stb[i]),
      .ldHalf    (loadHalf),
      .ldMode    (loadMode),
      .pendOut   (pend[i]),
      .clkOut    (outClock[i]),
      .tickOut   (outTick[i])
    );
  end

endmodule

// File: tb/tb_prog_clock_divider.sv
// Self-checking bench for prog_clock_divider with a
// cycle-level event model and directed sequences.
module tb_prog_clock_divider;

  localparam int NCH = 2;

  logic        clk;
  logic        rstn;
  logic        en;
  logic        sc;
  logic        lv;
  logic        rdy;
  logic [0:0]  lch;
  logic [13:0] lhalf;
  logic        lmode;
  logic [1:0]  oclk;
  logic [1:0]  otick;

  int n_chk;
  int n_fail;

  int m_pos[NCH];
  int m_half[NCH];
  int m_mode[NCH];
  int m_ph[NCH];
  int m_pm[NCH];
  int m_pend[NCH];
  int m_nev[NCH];
  int m_tick[NCH];

  prog_clock_divider #(
    .CNT_WIDTH    (14),
    .NUM_CH       (NCH),
    .DEFAULT_HALF (2)
  ) dut (
    .inClock   (clk),
    .resetN    (rstn),
    .enable    (en),
    .syncClear (sc),
    .loadValid (lv),
    .loadReady (rdy),
    .loadCh    (lch),
    .loadHalf  (lhalf),
    .loadMode  (lmode),
    .outClock  (oclk),
    .outTick   (otick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act,
                     input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d want %0d at %0t",
               nm, act, exp, $time);
    end
  endtask

  task automatic timeout(input string nm);
    n_chk++;
    n_fail++;
    $display("FAIL %s: timed out at %0t", nm, $time);
  endtask

  task automatic model_reset();
    for (int c = 0; c < NCH; c++) begin
      m_pos[c]  = 0;
      m_half[c] = 2;
      m_mode[c] = 0;
      m_pend[c] = 0;
      m_nev[c]  = 0;
      m_tick[c] = 0;
    end
  endtask

  function automatic int exp_ready();
    if (int'(lch) >= NCH) return 1;
    return m_pend[int'(lch)] ? 0 : 1;
  endfunction

  // Output clock = parity of toggle events since the
  // toggle run began; pulse mode keeps it low.
  function automatic int exp_clk(input int c);
    if (m_mode[c] != 0) return 0;
    return m_nev[c] % 2;
  endfunction

  task automatic apply_pend(input int c);
    m_half[c] = m_ph[c];
    m_mode[c] = m_pm[c];
    m_pend[c] = 0;
  endtask

  task automatic model_step();
    bit acc;
    bit mine;
    int oldm;
    acc = lv && (exp_ready() == 1);
    for (int c = 0; c < NCH; c++) begin
      mine = acc && (int'(lch) == c);
      if (sc) begin
        m_pos[c]  = 0;
        m_nev[c]  = 0;
        m_tick[c] = 0;
        if (mine) begin
          m_half[c] = int'(lhalf);
          m_mode[c] = int'(lmode);
          m_pend[c] = 0;
        end else if (m_pend[c] != 0) begin
          apply_pend(c);
        end
      end else begin
        m_tick[c] = 0;
        if (en && m_pos[c] == m_half[c]) begin
          m_pos[c] = 0;
          oldm = m_mode[c];
          if (m_pend[c] != 0) apply_pend(c);
          if (m_mode[c] == 1) begin
            m_nev[c]  = 0;
            m_tick[c] = 1;
          end else if (oldm == 1) begin
            m_nev[c] = 0;
          end else begin
            m_nev[c]++;
            m_tick[c] = m_nev[c] % 2;
          end
        end else if (en) begin
          m_pos[c]++;
        end
        if (mine) begin
          m_ph[c]   = int'(lhalf);
          m_pm[c]   = int'(lmode);
          m_pend[c] = 1;
        end
      end
    end
  endtask

  // One clock: check ready, clock edge, advance the
  // model, check outputs 1 ns later.
  task automatic step_chk(output bit r);
    #1;
    r = rdy;
    chk("ready", int'(rdy), exp_ready());
    @(posedge clk);
    model_step();
    #1;
    for (int c = 0; c < NCH; c++) begin
      chk("outClock", int'(oclk[c]), exp_clk(c));
      chk("outTick", int'(otick[c]), m_tick[c]);
    end
  endtask

  task automatic step();
    bit r;
    step_chk(r);
  endtask

  task automatic load(input int c, input int h,
                      input int m);
    lv    = 1'b1;
    lch   = 1'(c);
    lhalf = 14'(h);
    lmode = 1'(m);
    step();
    lv = 1'b0;
  endtask

  task automatic wait_applied(input int c);
    int k;
    k = 0;
    while (m_pend[c] != 0 && k < 40) begin
      step();
      k++;
    end
    if (m_pend[c] != 0) timeout("apply_wait");
  endtask

  typedef struct {
    bit       en;
    bit [1:0] clk;
    bit [1:0] tick;
  } vec_t;

  vec_t tbl[16];

  initial begin
    logic [15:0] cpat;
    logic [15:0] tpat;
    logic [7:0]  scpat;
    logic [7:0]  stpat;
    logic        held;
    int          pos0;
    int          want;
    int          got;
    bit          r;

    n_chk  = 0;
    n_fail = 0;
    cpat   = 16'b1100_0111_0001_1100;
    tpat   = 16'b0100_0001_0000_0100;
    for (int k = 0; k < 16; k++) begin
      tbl[k].en   = 1'b1;
      tbl[k].clk  = {2{cpat[k]}};
      tbl[k].tick = {2{tpat[k]}};
    end

    rstn  = 1'b0;
    en    = 1'b1;
    sc    = 1'b0;
    lv    = 1'b0;
    lch   = 1'b0;
    lhalf = '0;
    lmode = 1'b0;
    model_reset();

    #23;
    chk("rst_clk", int'(oclk), 0);
    chk("rst_tick", int'(otick), 0);
    chk("rst_ready", int'(rdy), 1);

    // Reset latency and period with half = 2.
    @(posedge clk);
    #1;
    rstn = 1'b1;
    for (int k = 0; k < 16; k++) begin
      en = tbl[k].en;
      step();
      chk("tbl_clk", int'(oclk), int'(tbl[k].clk));
      chk("tbl_tick", int'(otick), int'(tbl[k].tick));
    end

    // Ch1: half 4 toggle, then pulse half 0 mid-count.
    load(1, 4, 0);
    wait_applied(1);
    step();
    step();
    load(1, 0, 1);
    chk("ch1_wait_tick", int'(otick[1]), 0);
    wait_applied(1);
    for (int k = 0; k < 5; k++) begin
      step();
      chk("ch1_pulse_tick", int'(otick[1]), 1);
      chk("ch1_pulse_clk", int'(oclk[1]), 0);
    end

    // Back-to-back loads on ch0.
    load(0, 3, 0);
    lv    = 1'b1;
    lch   = 1'b0;
    lhalf = 14'd1;
    lmode = 1'b0;
    got   = 0;
    for (int k = 0; k < 30; k++) begin
      step_chk(r);
      if (r) begin
        got = 1;
        break;
      end
    end
    lv = 1'b0;
    if (got == 0) timeout("b2b_ready");
    wait_applied(0);

    // Freeze ch0 mid-period at half 5.
    load(0, 5, 0);
    wait_applied(0);
    step();
    step();
    pos0 = m_pos[0];
    held = oclk[0];
    en   = 1'b0;
    for (int k = 0; k < 7; k++) begin
      step();
      chk("frz_clk", int'(oclk[0]), int'(held));
      chk("frz_tick", int'(otick), 0);
    end
    en   = 1'b1;
    want = m_half[0] - pos0 + 1;
    got  = 0;
    for (int k = 1; k <= 20; k++) begin
      step();
      if (oclk[0] != held) begin
        got = k;
        break;
      end
    end
    if (got == 0) timeout("frz_resume");
    else chk("frz_remaining", got, want);

    // syncClear applies ch0's pending half 1.
    load(0, 1, 0);
    sc = 1'b1;
    step();
    sc = 1'b0;
    chk("sc_clk", int'(oclk), 0);
    chk("sc_tick", int'(otick), 0);
    scpat = 8'b0110_0110;
    stpat = 8'b0010_0010;
    for (int k = 0; k < 8; k++) begin
      step();
      chk("sc_clk0", int'(oclk[0]), int'(scpat[k]));
      chk("sc_tick0", int'(otick[0]), int'(stpat[k]));
    end

    // Async reset with a load in flight.
    load(0, 7, 0);
    #2;
    rstn = 1'b0;
    #1;
    chk("arst_clk", int'(oclk), 0);
    chk("arst_tick", int'(otick), 0);
    chk("arst_ready", int'(rdy), 1);
    model_reset();
    @(negedge clk);
    rstn = 1'b1;
    cpat = 16'b0000_0000_0000_0100;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("arst_rise", int'(oclk[0]), int'(cpat[k]));
    end

    // Randomized traffic against the model.
    for (int k = 0; k < 500; k++) begin
      en    = ($urandom % 8) != 0;
      sc    = ($urandom % 40) == 0;
      lv    = ($urandom % 4) == 0;
      lch   = 1'($urandom % 2);
      lhalf = 14'($urandom % 6);
      lmode = 1'($urandom % 2);
      step();
    end
    lv = 1'b0;
    sc = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
